// File: rtl/imm_stream_pkg.sv
// ----------------------------------------------------------------------------
// imm_stream_pkg
//   Shared types and constants for the imm frame-read stage.
//   - stream_state_e : top-level sequencer states (IDLE, RUN, DRAIN)
//   - PIX_W/I_W/J_W  : pixel, column and row widths
//   - pix_tag_t      : one pixel with its (i, j) coordinate and end-of-frame flag
// ----------------------------------------------------------------------------
package imm_stream_pkg;

    localparam int PIX_W = 12;
    localparam int I_W   = 9;
    localparam int J_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } stream_state_e;

    typedef struct packed {
        logic [PIX_W-1:0] pixel;
        logic [I_W-1:0]   i;
        logic [J_W-1:0]   j;
        logic             last;
    } pix_tag_t;

    localparam int TAG_W = $bits(pix_tag_t);

endpackage : imm_stream_pkg

// File: rtl/imm_skid_fifo.sv
// ----------------------------------------------------------------------------
// imm_skid_fifo
//   Two-entry FIFO that absorbs the one-cycle RAM read latency in front of a
//   valid/ready stream. A push and a pop in the same cycle are accepted even
//   when the FIFO is full; the new word lands in the slot being vacated.
//   flush_i empties the FIFO and takes priority over push/pop.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   flush_i      discard all entries
//   push_i       write wdata_i (ignored when full without a pop)
//   wdata_i      write data, DW bits
//   pop_i        remove the head entry (ignored when empty)
//   rdata_o      head entry, valid while count_o != 0
//   count_o      number of stored entries, 0..2
// ----------------------------------------------------------------------------
module imm_skid_fifo #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] mem_q [2];
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [1:0]    count_q,  count_d;
    logic          push_ok;
    logic          pop_ok;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        pop_ok   = pop_i && (count_q != 2'd0);
        push_ok  = push_i && ((count_q != 2'd2) || pop_ok);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_ok) wr_ptr_d = ~wr_ptr_q;
            if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; its contents are
    // only observed while count_q says an entry is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule : imm_skid_fifo

// File: rtl/imm_pixel_streamer.sv
// ----------------------------------------------------------------------------
// imm_pixel_streamer
//   Frame-read stage in front of the image masking unit. Reads a WIDTH x HEIGHT
//   frame in raster order from a synchronous RAM (1-cycle read latency) and
//   presents each pixel with its column (i_p) and row (j_p) on a valid/ready
//   stream. A 2-entry skid FIFO holds returned data, and reads are only issued
//   when the FIFO is guaranteed to have room for them.
// Optional feature
//   IMM_STREAM_ABORT_EN : adds input 'abort'; abort while busy flushes the
//                         stream, returns to IDLE and pulses done next cycle.
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   start       1-cycle pulse, begins a frame (ignored unless idle)
//   abort       (IMM_STREAM_ABORT_EN only) cancel the current frame
//   busy        frame in progress
//   done        1-cycle pulse when a frame finishes or is aborted
//   mem_rd_en   RAM read strobe
//   mem_addr    RAM address, j*WIDTH+i
//   mem_rdata   RAM data, valid one cycle after mem_rd_en
//   pix_valid   stream valid
//   pix_ready   stream ready
//   pixel       pixel value
//   i_p, j_p    column and row of pixel
//   frame_last  marks the beat at (WIDTH-1, HEIGHT-1)
// ----------------------------------------------------------------------------
module imm_pixel_streamer
    import imm_stream_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int AW     = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef IMM_STREAM_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic             mem_rd_en,
    output logic [AW-1:0]    mem_addr,
    input  logic [PIX_W-1:0] mem_rdata,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [PIX_W-1:0] pixel,
    output logic [I_W-1:0]   i_p,
    output logic [J_W-1:0]   j_p,
    output logic             frame_last
);

    stream_state_e  state_q, state_d;
    logic [I_W-1:0] rd_i_q, rd_i_d;
    logic [J_W-1:0] rd_j_q, rd_j_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           inflight_q, inflight_d;
    logic [I_W-1:0] tag_i_q, tag_i_d;
    logic [J_W-1:0] tag_j_q, tag_j_d;
    logic           tag_last_q, tag_last_d;
    logic           abort_done_q;

    logic           abort_w;
    logic           abort_hit;
    logic           rd_en;
    logic           drain_done;
    logic           pop;
    logic           last_addr;
    logic           row_end;
    logic [2:0]     occupancy;
    logic [1:0]     fifo_count;
    logic [TAG_W-1:0] fifo_rdata;
    pix_tag_t       head;
    pix_tag_t       push_tag;

`ifdef IMM_STREAM_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign abort_hit = abort_w && (state_q != IDLE);
    assign pop       = pix_valid && pix_ready;
    assign row_end   = (rd_i_q == I_W'(WIDTH - 1));
    assign last_addr = row_end && (rd_j_q == J_W'(HEIGHT - 1));
    // Entries already owed to the FIFO: stored ones plus a read still in flight.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};

    // Sequencer: next state, read issue and completion.
    always_comb begin
        state_d    = state_q;
        rd_en      = 1'b0;
        drain_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                // A pop this cycle frees a slot, so it counts toward room.
                rd_en = (occupancy < (3'd2 + {2'b00, pop}));
                if (rd_en && last_addr) state_d = DRAIN;
            end
            DRAIN: begin
                if ((fifo_count == 2'd0) && !inflight_q) begin
                    drain_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_hit) begin
            state_d    = IDLE;
            rd_en      = 1'b0;
            drain_done = 1'b0;
        end
    end

    // Read counters: column/row for tagging, plus a separate linear address.
    always_comb begin
        rd_i_d     = rd_i_q;
        rd_j_d     = rd_j_q;
        addr_d     = addr_q;
        tag_i_d    = tag_i_q;
        tag_j_d    = tag_j_q;
        tag_last_d = tag_last_q;
        inflight_d = rd_en;
        if (state_q == IDLE) begin
            rd_i_d = '0;
            rd_j_d = '0;
            addr_d = '0;
        end else if (rd_en) begin
            tag_i_d    = rd_i_q;
            tag_j_d    = rd_j_q;
            tag_last_d = last_addr;
            addr_d     = addr_q + 1'b1;
            if (row_end) begin
                rd_i_d = '0;
                rd_j_d = rd_j_q + 1'b1;
            end else begin
                rd_i_d = rd_i_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rd_i_q       <= '0;
            rd_j_q       <= '0;
            addr_q       <= '0;
            inflight_q   <= 1'b0;
            tag_i_q      <= '0;
            tag_j_q      <= '0;
            tag_last_q   <= 1'b0;
            abort_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_i_q       <= rd_i_d;
            rd_j_q       <= rd_j_d;
            addr_q       <= addr_d;
            inflight_q   <= inflight_d;
            tag_i_q      <= tag_i_d;
            tag_j_q      <= tag_j_d;
            tag_last_q   <= tag_last_d;
            abort_done_q <= abort_hit;
        end
    end

    // Returned RAM data joins the tag captured when its read was issued.
    always_comb begin
        push_tag       = '0;
        push_tag.pixel = mem_rdata;
        push_tag.i     = tag_i_q;
        push_tag.j     = tag_j_q;
        push_tag.last  = tag_last_q;
    end

    imm_skid_fifo #(
        .DW (TAG_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (abort_hit),
        .push_i  (inflight_q),
        .wdata_i (push_tag),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    assign head       = fifo_rdata;
    assign pix_valid  = (fifo_count != 2'd0);
    // Payload is forced to zero while invalid so idle outputs are clean.
    assign pixel      = pix_valid ? head.pixel : '0;
    assign i_p        = pix_valid ? head.i     : '0;
    assign j_p        = pix_valid ? head.j     : '0;
    assign frame_last = pix_valid && head.last;

    assign mem_rd_en  = rd_en;
    assign mem_addr   = addr_q;
    assign busy       = (state_q != IDLE);
    assign done       = drain_done || abort_done_q;

endmodule : imm_pixel_streamer

// File: tb/tb_imm_pixel_streamer.sv
// ----------------------------------------------------------------------------
// tb_imm_pixel_streamer
//   Self-checking bench for imm_pixel_streamer with a 4x3 frame and a RAM whose
//   word at address a is 12'h100+a. The expected beat list of a frame is built
//   arithmetically (k-th beat: pixel 0x100+k, i=k%W, j=k/W); one negedge
//   process compares the stream, read strobes, done and busy against it.
//   Covers the abort feature when IMM_STREAM_ABORT_EN is defined.
// ----------------------------------------------------------------------------
module tb_imm_pixel_streamer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 17;
    localparam int N  = W * H;

    typedef struct packed {
        logic [11:0] pixel;
        logic [8:0]  i;
        logic [7:0]  j;
        logic        last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [11:0]   mem_rdata = '0;
    logic          pix_valid;
    logic          pix_ready;
    logic [11:0]   pixel;
    logic [8:0]    i_p;
    logic [7:0]    j_p;
    logic          frame_last;
`ifdef IMM_STREAM_ABORT_EN
    logic          abort;
`endif

    imm_pixel_streamer #(
        .WIDTH  (W),
        .HEIGHT (H),
        .AW     (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
`ifdef IMM_STREAM_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pixel      (pixel),
        .i_p        (i_p),
        .j_p        (j_p),
        .frame_last (frame_last)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model: mem[a] = 12'h100 + a, one cycle of latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= 12'h100 + mem_addr[11:0];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    vectors     = 0;
    int    miscompares = 0;

    beat_t exp_q[$];
    int    issued, popped, beats, done_cnt, dc0, e0;
    int    first_rd_cyc, first_valid_cyc, first_hs_cyc, last_hs_cyc, done_cyc;
    bit    done_due, hold, frame_active, abort_next, ready_rand;
    beat_t hold_pl, first_beat, last_beat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ready driver: constant 1 or a 50% coin toss, changed just after each edge.
    initial begin
        pix_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pix_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: everything observed mid-cycle against the model.
    always @(negedge clk) begin
        beat_t act;
        int    pop_now;
        act     = '{pixel: pixel, i: i_p, j: j_p, last: frame_last};
        pop_now = (pix_valid && pix_ready) ? 1 : 0;
        if (!rst_n) begin
            check("reset_outputs",
                  {busy, done, mem_rd_en, pix_valid, frame_last, pixel, i_p, j_p, mem_addr}, '0);
            exp_q.delete();
            issued       = 0;
            popped       = 0;
            done_due     = 1'b0;
            hold         = 1'b0;
            frame_active = 1'b0;
            abort_next   = 1'b0;
        end else begin
            check("done", done, done_due);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (abort_next) begin
                check("abort_valid", pix_valid, 0);
                check("abort_busy", busy, 0);
            end else if (!done_due) begin
                check("busy", busy, frame_active);
            end
            done_due = 1'b0;

            if (mem_rd_en) begin
                check("rd_in_frame", frame_active, 1);
                check("rd_addr", mem_addr, issued);
                check("rd_room", ((issued - popped - pop_now) < 2) ? 1 : 0, 1);
                if (issued == 0) first_rd_cyc = cyc;
                issued++;
            end

            if (hold && !abort_next) begin
                check("hold_valid", pix_valid, 1);
                if (pix_valid) check("hold_payload", act, hold_pl);
            end
            hold = 1'b0;

            if (pix_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("beat_expected", 0, 1);
                end else begin
                    check("beat", act, exp_q[0]);
                    if (pix_ready) begin
                        if (beats == 0) begin
                            first_beat   = act;
                            first_hs_cyc = cyc;
                        end
                        last_beat   = act;
                        last_hs_cyc = cyc;
                        if (exp_q[0].last) begin
                            done_due     = 1'b1;
                            frame_active = 1'b0;
                        end
                        void'(exp_q.pop_front());
                        popped++;
                        beats++;
                    end else begin
                        hold    = 1'b1;
                        hold_pl = act;
                    end
                end
            end

            abort_next = 1'b0;
`ifdef IMM_STREAM_ABORT_EN
            if (abort && frame_active) begin
                done_due     = 1'b1;
                frame_active = 1'b0;
                abort_next   = 1'b1;
                hold         = 1'b0;
                exp_q.delete();
            end
`endif
        end
    end

    task automatic kick_frame();
        exp_q.delete();
        for (int k = 0; k < N; k++) begin
            exp_q.push_back('{pixel: 12'(32'h100 + k), i: 9'(k % W), j: 8'(k / W),
                              last: (k == N - 1)});
        end
        issued          = 0;
        popped          = 0;
        beats           = 0;
        first_rd_cyc    = -1;
        first_valid_cyc = -1;
        dc0             = done_cnt;
        start = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        e0           = cyc;
        frame_active = 1'b1;
    endtask

    task automatic wait_beats(input int k);
        int n = 0;
        while (beats < k && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("beats_timeout", (n < 400) ? 1 : 0, 1);
    endtask

    task automatic wait_frame();
        int n = 0;
        while (done_cnt == dc0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("frame_timeout", (n < 400) ? 1 : 0, 1);
        repeat (3) @(posedge clk);
        #1;
        check("frame_beats", beats, N);
        check("frame_dones", done_cnt - dc0, 1);
        check("busy_after", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        ready_rand = 1'b0;
        done_cnt   = 0;
`ifdef IMM_STREAM_ABORT_EN
        abort      = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1. Reset, no start: stays idle with no reads.
        repeat (20) @(posedge clk);
        #1;
        check("idle_outputs", {busy, done, mem_rd_en, pix_valid, pixel, i_p, j_p, frame_last}, '0);
        check("idle_dones", done_cnt, 0);

        // 2. Full-rate frame with literal expectations pinning the model.
        kick_frame();
        wait_frame();
        check("first_rd_latency", first_rd_cyc, e0);
        check("first_valid_latency", first_valid_cyc, e0 + 2);
        check("no_bubbles", last_hs_cyc - first_hs_cyc, N - 1);
        check("first_beat", first_beat, {12'h100, 9'd0, 8'd0, 1'b0});
        check("last_beat", last_beat, {12'h10B, 9'd3, 8'd2, 1'b1});
        check("done_cycle", done_cyc, last_hs_cyc + 1);

        // 3. Random backpressure.
        ready_rand = 1'b1;
        for (int f = 0; f < 4; f++) begin
            kick_frame();
            wait_frame();
        end

        // 4. A second start while busy is ignored.
        kick_frame();
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_frame();

        // 5. Reset mid-frame, then a clean full frame.
        ready_rand = 1'b0;
        kick_frame();
        wait_beats(5);
        dc0   = done_cnt;
        rst_n = 1'b0;
        #1;
        check("reset_now", {busy, done, pix_valid, mem_rd_en}, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_no_done", done_cnt - dc0, 0);
        kick_frame();
        wait_frame();
        check("after_reset_first", first_beat, {12'h100, 9'd0, 8'd0, 1'b0});

`ifdef IMM_STREAM_ABORT_EN
        // 6. Abort after beat 3, then restart.
        ready_rand = 1'b1;
        kick_frame();
        wait_beats(3);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_dones", done_cnt - dc0, 1);
        check("abort_idle", {busy, pix_valid}, '0);
        kick_frame();
        wait_frame();
        check("abort_restart_first", first_beat, {12'h100, 9'd0, 8'd0, 1'b0});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_imm_pixel_streamer
